// File: rtl/jk_cnt_pkg.sv
// Shared types and helpers for the JK-flop based up/down counter.
package jk_cnt_pkg;

    // One JK control pair per flop.
    typedef struct packed {
        logic j;
        logic k;
    } jk_pair_t;

    // {J,K} encodings for a single flop.
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Drive J or K only on bits that must change; never both, so toggle is unused here.
    function automatic jk_pair_t jk_from_next(input logic q_bit, input logic n_bit);
        jk_pair_t p;
        p.j = n_bit & ~q_bit;
        p.k = ~n_bit & q_bit;
        return p;
    endfunction

endpackage

// File: rtl/sync_updown_jk_cnt_jk_ff.sv
// Single-bit JK flip-flop, async active-low reset clears q.
module jk_ff
    import jk_cnt_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    // JK state update; reset forces 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD:   q <= q;
                JK_RESET:  q <= 1'b0;
                JK_SET:    q <= 1'b1;
                JK_TOGGLE: q <= ~q;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/sync_updown_jk_cnt.sv
// Synchronous up/down modulo-MODULUS counter made of per-bit JK flops.
// Optional macro JK_CNT_SATURATE_EN: saturate at the ends instead of wrapping.
module sync_updown_jk_cnt
    import jk_cnt_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam longint unsigned SPAN = 64'd1 << WIDTH;

    generate
        if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || 64'(MODULUS) > SPAN) begin : g_bad_param
            $error("sync_updown_jk_cnt: illegal WIDTH/MODULUS combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO    = '0;

    logic [WIDTH-1:0] n;
    logic             at_max;
    logic             at_min;

    assign at_max = (q == MAX_VAL);
    assign at_min = (q == ZERO);

    // Next count: load (clamped) over count over hold; wrap compare kept explicit.
    always_comb begin
        n = q;
        if (load) begin
            n = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            if (up_dn) begin
`ifdef JK_CNT_SATURATE_EN
                n = at_max ? MAX_VAL : q + ONE;
`else
                n = at_max ? ZERO : q + ONE;
`endif
            end else begin
`ifdef JK_CNT_SATURATE_EN
                n = at_min ? ZERO : q - ONE;
`else
                n = at_min ? MAX_VAL : q - ONE;
`endif
            end
        end
    end

    // Terminal count: flags the cycle before a wrap edge; forced low while in reset.
    always_comb begin
        tc = reset & en & ~load & ((up_dn & at_max) | (~up_dn & at_min));
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            jk_pair_t jk;
            assign jk = jk_from_next(q[i], n[i]);

            jk_ff u_jk_ff (
                .clk   (clk),
                .reset (reset),
                .j     (jk.j),
                .k     (jk.k),
                .q     (q[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sync_updown_jk_cnt.sv
// Self-checking bench: arithmetic reference model compared every negedge, plus literal checks.
module tb_sync_updown_jk_cnt;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic         up_dn = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] q;
    logic         tc;

    int checks = 0;
    int errors = 0;
    int model_q = 0;
    bit run_cmp = 1'b1;

    sync_updown_jk_cnt #(.WIDTH(W), .MODULUS(MOD)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    // Reference model from the behavioural rules, using integer arithmetic.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_q <= 0;
        end else if (load) begin
            model_q <= (int'(load_val) > MOD - 1) ? MOD - 1 : int'(load_val);
        end else if (en) begin
`ifdef JK_CNT_SATURATE_EN
            if (up_dn) model_q <= (model_q + 1 > MOD - 1) ? MOD - 1 : model_q + 1;
            else       model_q <= (model_q - 1 < 0) ? 0 : model_q - 1;
`else
            if (up_dn) model_q <= (model_q + 1) % MOD;
            else       model_q <= (model_q + MOD - 1) % MOD;
`endif
        end
    end

    function automatic logic model_tc();
        return reset && en && !load &&
               ((up_dn && model_q == MOD - 1) || (!up_dn && model_q == 0));
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("model_q", 32'(q), 32'(model_q));
            chk("model_tc", 32'(tc), 32'(model_tc()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_up[12];
    int exp_dn[4];

    initial begin
        // Reset held while clocking; tc must stay low even with en & down at q=0.
        repeat (3) tick();
        chk("rst_q", 32'(q), 0);
        chk("rst_tc", 32'(tc), 0);
        en = 1'b1; up_dn = 1'b0;
        #1;
        chk("rst_tc_gated", 32'(tc), 0);
        en = 1'b0; up_dn = 1'b1;
        #3 reset = 1'b1;  // mid-cycle release
        #1;
        chk("rel_q", 32'(q), 0);
        tick();
        chk("rel_hold_q", 32'(q), 0);

`ifndef JK_CNT_SATURATE_EN
        // Up count with wrap at 9.
        exp_up = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("up_tc", 32'(tc), (i == 9) ? 1 : 0);
            tick();
            chk("up_q", 32'(q), 32'(exp_up[i]));
        end

        // Down count with wrap at 0.
        exp_dn = '{1, 0, 9, 8};
        up_dn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("dn_tc", 32'(tc), (i == 2) ? 1 : 0);
            tick();
            chk("dn_q", 32'(q), 32'(exp_dn[i]));
        end
`endif

        // Load in range, then out of range (clamp), en high; tc suppressed by load.
        load = 1'b1; en = 1'b1; up_dn = 1'b1; load_val = 4'd7;
        #1;
        chk("ld7_tc", 32'(tc), 0);
        tick();
        chk("ld7_q", 32'(q), 7);
        load_val = 4'd14;
        #1;
        chk("ld14_tc", 32'(tc), 0);
        tick();
        chk("ld14_q", 32'(q), 9);
        #1;
        chk("ld_at9_tc", 32'(tc), 0);
        load = 1'b0;
        #1;
        chk("at9_tc", 32'(tc), 1);

        // Async reset between edges at q=6, then hold with en=0.
        load = 1'b1; load_val = 4'd6;
        tick();
        chk("ld6_q", 32'(q), 6);
        load = 1'b0; en = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_q", 32'(q), 0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_q", 32'(q), 0);
        end

`ifdef JK_CNT_SATURATE_EN
        // Saturating up then down from 0.
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("sat_up_q", 32'(q), (i + 1 > 9) ? 9 : i + 1);
        end
        up_dn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("sat_dn_q", 32'(q), (8 - i < 0) ? 0 : 8 - i);
        end
`endif

        // Short random-ish run against the model.
        for (int i = 0; i < 40; i++) begin
            en       = 1'($urandom_range(0, 1));
            up_dn    = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 7) == 0);
            load_val = W'($urandom_range(0, 15));
            tick();
        end

        run_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
